// File: rtl/aqp_z80_bus_target.sv
// Z80 bus responder: decodes memory/I/O windows into a req/ack internal bus,
// stretches the CPU cycle with wait_n, and owns one IM2 interrupt source.
`timescale 1ns/1ps
`default_nettype none

module aqp_z80_bus_target #(
   parameter logic [15:0] MEM_BASE = 16'h0000,
   parameter logic [15:0] MEM_MASK = 16'h0000,
   parameter logic [7:0]  IO_BASE  = 8'h00,
   parameter logic [7:0]  IO_MASK  = 8'hFF,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] addr,
   input  logic [7:0]  dq_in,
   output logic [7:0]  dq_out,
   output logic        dq_oe,
   input  logic        mreq_n,
   input  logic        iorq_n,
   input  logic        rd_n,
   input  logic        wr_n,
   input  logic        m1_n,
   input  logic        rfsh_n,
   output logic        wait_n,
   output logic        int_n,
   output logic        req,
   output logic [15:0] req_addr,
   output logic [7:0]  req_wrdata,
   output logic        req_wr,
   output logic        req_io,
   input  logic [7:0]  req_rddata,
   input  logic        req_ack,
   input  logic        irq_set,
   input  logic [7:0]  int_vector,
   output logic        irq_ack
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_HOLD   = 2'd2,
      ST_INTACK = 2'd3
   } state_t;

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic [7:0]  cnt_d;
   logic        abort_q;
   logic        pending_q;
   logic        wait_n_q;
   logic        req_q;
   logic        irq_ack_q;
   logic [7:0]  dq_out_q;
   logic [15:0] req_addr_q;
   logic [7:0]  req_wrdata_q;
   logic        req_wr_q;
   logic        req_io_q;

   logic strobe;
   logic strobes_idle;
   logic mem_hit;
   logic io_hit;
   logic intack;
   logic timeout_hit;

   assign strobe       = !rd_n || !wr_n;
   assign strobes_idle = rd_n && wr_n;
   assign mem_hit      = !mreq_n && rfsh_n && strobe &&
                         (((addr ^ MEM_BASE) & MEM_MASK) == 16'h0000) &&
                         (MEM_MASK != 16'h0000);
   assign io_hit       = !iorq_n && m1_n && strobe &&
                         (((addr[7:0] ^ IO_BASE) & IO_MASK) == 8'h00);
   assign intack       = !iorq_n && !m1_n && pending_q;

   // cnt_d is the number of cycles spent in ACCESS including the current one
   assign cnt_d       = cnt_q + 8'd1;
   assign timeout_hit = (cnt_d == TIMEOUT_C);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 8'h00;
         abort_q      <= 1'b0;
         pending_q    <= 1'b0;
         wait_n_q     <= 1'b1;
         req_q        <= 1'b0;
         irq_ack_q    <= 1'b0;
         dq_out_q     <= 8'h00;
         req_addr_q   <= 16'h0000;
         req_wrdata_q <= 8'h00;
         req_wr_q     <= 1'b0;
         req_io_q     <= 1'b0;
      end else begin
         req_q     <= 1'b0;
         irq_ack_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (mem_hit || io_hit) begin
                  req_q        <= 1'b1;
                  req_addr_q   <= addr;
                  req_wr_q     <= !wr_n;
                  req_io_q     <= io_hit;
                  req_wrdata_q <= dq_in;
                  wait_n_q     <= 1'b0;
                  cnt_q        <= 8'h00;
                  abort_q      <= 1'b0;
                  state_q      <= ST_ACCESS;
               end else if (intack) begin
                  dq_out_q  <= int_vector;
                  irq_ack_q <= 1'b1;
                  pending_q <= 1'b0;
                  state_q   <= ST_INTACK;
               end
            end
            ST_ACCESS: begin
               cnt_q <= cnt_d;
               if (req_ack || timeout_hit) begin
                  wait_n_q <= 1'b1;
                  // An abandoned CPU cycle drops the late result entirely
                  if (abort_q || strobes_idle) begin
                     state_q <= ST_IDLE;
                  end else begin
                     state_q <= ST_HOLD;
                     if (req_ack) begin
                        if (!req_wr_q) dq_out_q <= req_rddata;
                     end else begin
                        dq_out_q <= 8'hFF;
                     end
                  end
               end else if (strobes_idle) begin
                  wait_n_q <= 1'b1;
                  abort_q  <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (strobes_idle) state_q <= ST_IDLE;
            end
            ST_INTACK: begin
               if (iorq_n) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
         if (irq_set) pending_q <= 1'b1;
      end
   end

   // Drive enable is combinational so the bus is released the moment the CPU strobe drops
   assign dq_oe = ((state_q == ST_HOLD) && !req_wr_q && !rd_n) ||
                  ((state_q == ST_INTACK) && !iorq_n && !m1_n);

   assign dq_out     = dq_out_q;
   assign wait_n     = wait_n_q;
   assign int_n      = !pending_q;
   assign req        = req_q;
   assign req_addr   = req_addr_q;
   assign req_wrdata = req_wrdata_q;
   assign req_wr     = req_wr_q;
   assign req_io     = req_io_q;
   assign irq_ack    = irq_ack_q;

endmodule

`default_nettype wire

// File: doc/aqp_z80_bus_target.md
Name: aqp_z80_bus_target

Overview:
Responder-side Z80 bus interface: the peripheral end of the bus driven by the T80 CPU core.
- Decodes memory and I/O strobes against configurable windows.
- Converts each hit into a single-cycle request on a simple internal req/ack bus.
- Stretches the CPU cycle with wait_n until the backing logic acknowledges, and drives read data back onto dq.
- Owns one interrupt source: raises int_n and supplies an IM2 vector during interrupt-acknowledge cycles.

Parameters:
MEM_BASE, 16'h0000, memory window base (compared under MEM_MASK)
MEM_MASK, 16'h0000, memory address bits compared; 0 disables memory decode
IO_BASE, 8'h00, I/O port base (compared against addr[7:0] under IO_MASK)
IO_MASK, 8'hFF, I/O port bits compared
TIMEOUT, 255, max clk cycles in ACCESS before wait is forcibly released (8-bit counter)

Ports:
clk  in  1  system clock; all bus inputs are synchronous to it
reset  in  1  asynchronous, active-high
addr  in  16  Z80 address
dq_in  in  8  Z80 data bus (CPU write data)
dq_out  out  8  data driven to CPU
dq_oe  out  1  dq_out drive enable
mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n  in  1 each  Z80 control strobes, active-low
wait_n  out  1  wait request to CPU, active-low
int_n  out  1  interrupt request to CPU, active-low
req  out  1  one-cycle internal access request
req_addr  out  16  latched address
req_wrdata  out  8  latched write data
req_wr  out  1  1 = write
req_io  out  1  1 = I/O, 0 = memory
req_rddata  in  8  read data, valid with req_ack
req_ack  in  1  one-cycle acknowledge
irq_set  in  1  pulse: set interrupt pending
int_vector  in  8  IM2 vector byte
irq_ack  out  1  one-cycle pulse when the CPU acknowledges our interrupt

Behaviour:
- Reset values: state IDLE; wait_n=1; int_n=1; dq_oe=0; req=0; irq_ack=0; pending=0; dq_out=8'h00; timeout counter=0.
- Hit conditions:
  - mem_hit = !mreq_n && rfsh_n && m1_n-independent && (!rd_n || !wr_n) && ((addr ^ MEM_BASE) & MEM_MASK) == 0 && MEM_MASK != 0.
  - io_hit = !iorq_n && m1_n && (!rd_n || !wr_n) && ((addr[7:0] ^ IO_BASE) & IO_MASK) == 0.
  - intack = !iorq_n && !m1_n && pending.
- States: IDLE, ACCESS, HOLD, INTACK.
- IDLE:
  - On mem_hit or io_hit, at the next edge: req=1 (one cycle), latch req_addr=addr, req_wr=!wr_n, req_io=io_hit, req_wrdata=dq_in; wait_n<=0; counter<=0; go to ACCESS.
  - On intack, at the next edge: dq_out<=int_vector; irq_ack=1 (one cycle); pending<=0; go to INTACK.
  - Refresh cycles (rfsh_n=0) and non-decoded cycles cause no response: wait_n=1, dq_oe=0.
- ACCESS:
  - Counter increments each cycle.
  - On req_ack: dq_out<=req_rddata (reads only; writes leave dq_out unchanged); wait_n<=1; go to HOLD.
  - On counter==TIMEOUT without ack: dq_out<=8'hFF; wait_n<=1; go to HOLD. A req_ack arriving later is ignored.
  - If both rd_n and wr_n go high before ack (aborted cycle): wait_n<=1 immediately; stay in ACCESS until ack or timeout, then go to IDLE directly. The late result is discarded.
- HOLD: when rd_n and wr_n are both high, go to IDLE. A new access is not accepted until IDLE is re-entered, so exactly one req is issued per CPU strobe.
- INTACK: when iorq_n is high, go to IDLE.
- dq_oe (combinational, prevents bus contention):
  - (HOLD && !req_wr && !rd_n), or
  - (INTACK && !iorq_n && !m1_n).
- Interrupt:
  - int_n = !pending.
  - irq_set sets pending. irq_set coincident with irq_ack leaves pending=1 (set wins).
  - INTACK is entered only when pending=1; otherwise an intack cycle belongs to another device and is ignored.
- Reset asserted mid-operation immediately forces all reset values, including wait_n=1 and dq_oe=0.

Test Plan:
1. MEM_BASE=16'h8000, MEM_MASK=16'hC000; CPU reads 16'h8123; req_ack 3 cycles after req with req_rddata=8'h5A -> exactly one req pulse, req_addr=16'h8123, req_wr=0, req_io=0; wait_n low for 3 cycles; dq_oe=1 with dq_out=8'h5A until rd_n rises; then IDLE.
2. IO_BASE=8'hF0, IO_MASK=8'hF0; CPU writes 8'hA7 to port 8'hF5 -> req_io=1, req_wr=1, req_wrdata=8'hA7; dq_oe stays 0 throughout. A write to port 8'h35 produces no req and wait_n stays 1.
3. Refresh cycle to an in-window address (mreq_n=0, rfsh_n=0) -> no req, wait_n=1, dq_oe=0.
4. TIMEOUT=4 with req_ack never asserted on a read -> wait_n releases after 4 cycles; dq_out=8'hFF; a later req_ack does not change dq_out.
5. irq_set pulse -> int_n=0. intack cycle with int_vector=8'hE0 -> dq_out=8'hE0, dq_oe=1 while iorq_n=0, one irq_ack pulse, int_n=1. A repeat with irq_set coincident with irq_ack -> int_n remains 0.
6. reset asserted while in ACCESS with wait_n=0 -> wait_n=1 and dq_oe=0 asynchronously. After reset release, no residual req and state is IDLE.
